// File: rtl/packed_field_shadow_reg_pkg.sv
// Shared types and helpers for the packed field shadow register: FSM state encoding,
// default geometry and the read-window base calculation.
package packed_field_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_FIELD_W = 4;
  localparam int unsigned NUM_FIELDS  = DEF_WIDTH / DEF_FIELD_W;

  function automatic int unsigned field_base(input int unsigned sel, input int unsigned field_w);
    return sel * field_w;
  endfunction

endpackage

// File: rtl/packed_field_shadow_reg_if.sv
// Bus bundle between the register and its user: write handshake, commit request,
// read window select and the committed/readback outputs.
interface packed_field_shadow_reg_if
  import packed_field_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IN_W       = 10,
  parameter int NUM_FIELDS = 4,
  parameter int OUT_W      = 5,
  parameter int SEL_W      = 2
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [IN_W-1:0]       wr_data;
  logic [NUM_FIELDS-1:0] wr_field_mask;
  logic                  bit0_ovr_en;
  logic                  bit0_ovr_val;
  logic                  commit;
  logic [SEL_W-1:0]      rd_sel;
  logic [OUT_W-1:0]      rd_data;
  logic [WIDTH-1:0]      shadow_out;
  logic [7:0]            commit_count;

  modport master (
    output wr_valid, wr_data, wr_field_mask, bit0_ovr_en, bit0_ovr_val, commit, rd_sel,
    input  wr_ready, rd_data, shadow_out, commit_count
  );

  modport slave (
    input  wr_valid, wr_data, wr_field_mask, bit0_ovr_en, bit0_ovr_val, commit, rd_sel,
    output wr_ready, rd_data, shadow_out, commit_count
  );

endinterface

// File: rtl/packed_field_shadow_reg_merge.sv
// Combinational next-value of the working register: masked field write, then forced
// upper bits, then the bit-0 override (each later step takes precedence).
module packed_field_merge #(
  parameter int   WIDTH   = 16,
  parameter int   IN_W    = 10,
  parameter int   FIELD_W = 4,
  parameter logic FILL    = 1'b1
) (
  input  logic [WIDTH-1:0]         work_i,
  input  logic [IN_W-1:0]          wr_data_i,
  input  logic [WIDTH/FIELD_W-1:0] field_mask_i,
  input  logic                     ovr_en_i,
  input  logic                     ovr_val_i,
  output logic [WIDTH-1:0]         merged_o
);

  localparam int NF = WIDTH / FIELD_W;

  logic [WIDTH-1:0] data_ext_s;

  assign data_ext_s = WIDTH'(wr_data_i);

  // Field merge, then force, then override; order gives the override final say on bit 0.
  always_comb begin
    merged_o = work_i;
    for (int f = 0; f < NF; f++) begin
      if (field_mask_i[f]) begin
        merged_o[f*FIELD_W +: FIELD_W] = data_ext_s[f*FIELD_W +: FIELD_W];
      end else begin
        merged_o[f*FIELD_W +: FIELD_W] = work_i[f*FIELD_W +: FIELD_W];
      end
    end
    for (int i = IN_W; i < WIDTH; i++) begin
      merged_o[i] = FILL;
    end
    if (ovr_en_i) begin
      merged_o[0] = ovr_val_i;
    end else begin
      merged_o[0] = merged_o[0];
    end
  end

endmodule

// File: rtl/packed_field_shadow_reg.sv
// Working register with masked writes, committed to a shadow copy by a two-state FSM;
// a registered window of the shadow is read back with its LSB duplicated.
module packed_field_shadow_reg
  import packed_field_pkg::*;
#(
  parameter int   WIDTH   = 16,
  parameter int   IN_W    = 10,
  parameter int   FIELD_W = 4,
  parameter int   OUT_W   = 5,
  parameter logic FILL    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  packed_field_shadow_reg_if.slave  bus
);

  localparam int N_FIELDS = WIDTH / FIELD_W;
  localparam int BASE_W   = $clog2(WIDTH + OUT_W) + 1;

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_COMMIT = COMMIT;

  localparam logic [WIDTH-1:0] RST_VAL = {{(WIDTH-IN_W){FILL}}, {IN_W{1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [OUT_W-1:0] rd_data_q, rd_data_d;
  logic [7:0]       count_q, count_d;

  logic                    wr_ready_s;
  logic                    accept_s;
  logic [WIDTH-1:0]        merged_s;
  logic [WIDTH+OUT_W-1:0]  ext_s;
  logic [BASE_W-1:0]       shift_s;
  logic [OUT_W-2:0]        win_s;

  packed_field_merge #(
    .WIDTH   (WIDTH),
    .IN_W    (IN_W),
    .FIELD_W (FIELD_W),
    .FILL    (FILL)
  ) u_merge (
    .work_i       (work_q),
    .wr_data_i    (bus.wr_data),
    .field_mask_i (bus.wr_field_mask[N_FIELDS-1:0]),
    .ovr_en_i     (bus.bit0_ovr_en),
    .ovr_val_i    (bus.bit0_ovr_val),
    .merged_o     (merged_s)
  );

  assign wr_ready_s = (state_q == ST_IDLE);
  assign accept_s   = bus.wr_valid & wr_ready_s;

  // FSM, working register, shadow copy and commit counter next-state.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          work_d = merged_s;
        end else begin
          work_d = work_q;
        end
        if (bus.commit) begin
          state_d = ST_COMMIT;
          count_d = count_q + 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        shadow_d = work_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read window: shift past the duplicated LSB position; bits beyond WIDTH come from zero padding.
  always_comb begin
    ext_s     = {{OUT_W{1'b0}}, shadow_q};
    shift_s   = BASE_W'(field_base(32'(bus.rd_sel), 32'(FIELD_W)) + 32'd1);
    win_s     = (OUT_W-1)'(ext_s >> shift_s);
    rd_data_d = {win_s, win_s[0]};
  end

  // State and data flops; reset abandons any in-flight commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      work_q    <= RST_VAL;
      shadow_q  <= RST_VAL;
      rd_data_q <= {OUT_W{1'b0}};
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
      count_q   <= count_d;
    end
  end

  assign bus.wr_ready     = wr_ready_s;
  assign bus.rd_data      = rd_data_q;
  assign bus.shadow_out   = shadow_q;
  assign bus.commit_count = count_q;

endmodule
